// File: rtl/anc_lms_filter_if.sv
// anc_lms_filter_if
// Sample handshake and data bundle between the ANC sample source (bench or
// mic front end) and the adaptive LMS filter.
//   ready_in            one-cycle pulse, new sample pair valid
//   adapt_en_in         1 = adapt coefficients for this sample
//   x_sample_in         signed Q1.15 ambient reference sample
//   error_sample_in     signed Q1.15 error sample for the previous output
//   speaker_output_out  signed 8-bit anti-noise sample
//   done_out            one-cycle pulse, speaker_output_out updated
//   busy_out            filter is processing a sample
//   overrun_out         sticky, a sample arrived while busy
// master = sample source, slave = filter.
interface anc_lms_filter_if;
   logic              ready_in;
   logic              adapt_en_in;
   logic signed [15:0] x_sample_in;
   logic signed [15:0] error_sample_in;
   logic signed [7:0]  speaker_output_out;
   logic              done_out;
   logic              busy_out;
   logic              overrun_out;

   modport master (
      output ready_in, adapt_en_in, x_sample_in, error_sample_in,
      input  speaker_output_out, done_out, busy_out, overrun_out
   );

   modport slave (
      input  ready_in, adapt_en_in, x_sample_in, error_sample_in,
      output speaker_output_out, done_out, busy_out, overrun_out
   );
endinterface

// File: rtl/anc_lms_filter.sv
// anc_lms_filter
// Time-multiplexed adaptive LMS FIR producing the ANC speaker drive. One MAC
// per cycle: a sample pair is accepted in IDLE, every coefficient is adapted
// against the pre-insertion history, the new reference sample is inserted,
// the FIR sum is accumulated serially and the saturated result is published
// with a one-cycle done pulse (2*NUM_TAPS+2 cycles after the accepting edge).
// Ports:
//   clk_in    system clock
//   rst_n_in  asynchronous active-low reset (clears coefficients and history)
//   bus       anc_lms_filter_if.slave sample handshake and data
module anc_lms_filter #(
   parameter int NUM_TAPS = 32,
   parameter int MU_SHIFT = 12,
   parameter int COEF_W   = 16
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   anc_lms_filter_if.slave    bus
);

   localparam int PTR_W  = $clog2(NUM_TAPS);
   localparam int PROD_W = COEF_W + 16;
   localparam int ACC_W  = PROD_W + PTR_W;
   localparam int UPD_W  = ((COEF_W > 32) ? COEF_W : 32) + 1;

   localparam logic signed [UPD_W-1:0] COEF_MAX = UPD_W'((1 << (COEF_W - 1)) - 1);
   localparam logic signed [UPD_W-1:0] COEF_MIN = UPD_W'(-(1 << (COEF_W - 1)));
   localparam logic [PTR_W-1:0]        LAST_TAP = PTR_W'(NUM_TAPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UPDATE,
      S_INSERT,
      S_FILTER,
      S_OUTPUT
   } state_t;

   state_t state, state_nxt;

   logic signed [COEF_W-1:0] coef [NUM_TAPS];
   logic signed [15:0]       hist [NUM_TAPS];

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   tap_cnt;
   logic signed [15:0] x_lat;
   logic signed [15:0] e_lat;
   logic               adapt_lat;
   logic signed [ACC_W-1:0] acc;
   logic signed [7:0]  speaker;
   logic               done;
   logic               overrun;

   function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [UPD_W-1:0] v);
      if (v > COEF_MAX)
         return COEF_MAX[COEF_W-1:0];
      else if (v < COEF_MIN)
         return COEF_MIN[COEF_W-1:0];
      else
         return v[COEF_W-1:0];
   endfunction

   function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
      if (v > ACC_W'(127))
         return 8'sd127;
      else if (v < ACC_W'(-128))
         return -8'sd128;
      else
         return v[7:0];
   endfunction

   // Tap k lives at (wr_ptr - 1 - k); tap 0 is the newest sample.
   logic [PTR_W-1:0]          tap_addr;
   logic signed [15:0]        x_tap;
   logic signed [COEF_W-1:0]  w_tap;
   logic signed [31:0]        ex_prod;
   logic signed [31:0]        ex_shift;
   logic signed [UPD_W-1:0]   upd_sum;
   logic signed [COEF_W-1:0]  w_next;
   logic signed [PROD_W-1:0]  wx_prod;
   logic signed [ACC_W-1:0]   acc_next;
   logic signed [ACC_W-1:0]   acc_shift;
   logic                      last_tap;

   assign tap_addr  = wr_ptr - PTR_W'(1) - tap_cnt;
   assign x_tap     = hist[tap_addr];
   assign w_tap     = coef[tap_cnt];
   assign ex_prod   = 32'(e_lat) * 32'(x_tap);
   assign ex_shift  = ex_prod >>> MU_SHIFT;
   // Minus sign: the downstream stage adds the speaker output to ambient.
   assign upd_sum   = UPD_W'(w_tap) - UPD_W'(ex_shift);
   assign w_next    = sat_coef(upd_sum);
   assign wx_prod   = PROD_W'(w_tap) * PROD_W'(x_tap);
   assign acc_next  = acc + ACC_W'(wx_prod);
   assign acc_shift = acc >>> 23;
   assign last_tap  = (tap_cnt == LAST_TAP);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.ready_in) state_nxt = S_UPDATE;
         S_UPDATE: if (last_tap)     state_nxt = S_INSERT;
         S_INSERT:                   state_nxt = S_FILTER;
         S_FILTER: if (last_tap)     state_nxt = S_OUTPUT;
         S_OUTPUT:                   state_nxt = S_IDLE;
         default:                    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr    <= '0;
         tap_cnt   <= '0;
         x_lat     <= '0;
         e_lat     <= '0;
         adapt_lat <= 1'b0;
         acc       <= '0;
         speaker   <= '0;
         done      <= 1'b0;
         overrun   <= 1'b0;
         for (int i = 0; i < NUM_TAPS; i++) begin
            coef[i] <= '0;
            hist[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         // Only IDLE accepts a sample; anything else (OUTPUT included) is an overrun.
         if (bus.ready_in && (state != S_IDLE))
            overrun <= 1'b1;
         case (state)
            // Latch the sample pair
            S_IDLE: begin
               if (bus.ready_in) begin
                  x_lat     <= bus.x_sample_in;
                  e_lat     <= bus.error_sample_in;
                  adapt_lat <= bus.adapt_en_in;
                  tap_cnt   <= '0;
               end
            end
            // Coefficient update against pre-insertion history
            S_UPDATE: begin
               if (adapt_lat)
                  coef[tap_cnt] <= w_next;
               tap_cnt <= tap_cnt + PTR_W'(1);
            end
            // History insert; the oldest entry is overwritten
            S_INSERT: begin
               hist[wr_ptr] <= x_lat;
               wr_ptr       <= wr_ptr + PTR_W'(1);
               acc          <= '0;
               tap_cnt      <= '0;
            end
            // Serial FIR accumulation
            S_FILTER: begin
               acc     <= acc_next;
               tap_cnt <= tap_cnt + PTR_W'(1);
            end
            // Publish
            S_OUTPUT: begin
               speaker <= sat8(acc_shift);
               done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.speaker_output_out = speaker;
   assign bus.done_out           = done;
   assign bus.busy_out           = (state != S_IDLE);
   assign bus.overrun_out        = overrun;

endmodule

// File: tb/tb_anc_lms_filter.sv
// tb_anc_lms_filter
// Self-checking bench for anc_lms_filter. A queue-based reference model of the
// LMS update / FIR sum predicts every speaker sample; each scenario task
// drives its own stimulus and compares inline.
module tb_anc_lms_filter;

   localparam int NUM_TAPS = 32;
   localparam int MU_SHIFT = 12;
   localparam int COEF_W   = 16;
   localparam int LAT      = 2 * NUM_TAPS + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   anc_lms_filter_if bus();

   anc_lms_filter #(
      .NUM_TAPS (NUM_TAPS),
      .MU_SHIFT (MU_SHIFT),
      .COEF_W   (COEF_W)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: coefficients by tap, history as a queue with x[0] newest.
   int w_m [NUM_TAPS];
   int x_q [$];

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic void model_reset();
      x_q.delete();
      for (int k = 0; k < NUM_TAPS; k++) begin
         w_m[k] = 0;
         x_q.push_back(0);
      end
   endfunction

   function automatic int model_step(input int x, input int e, input bit ad);
      longint acc;
      if (ad) begin
         for (int k = 0; k < NUM_TAPS; k++)
            w_m[k] = int'(clamp(longint'(w_m[k]) - ((longint'(e) * longint'(x_q[k])) >>> MU_SHIFT),
                                -32768, 32767));
      end
      x_q.push_front(x);
      void'(x_q.pop_back());
      acc = 0;
      for (int k = 0; k < NUM_TAPS; k++)
         acc += longint'(w_m[k]) * longint'(x_q[k]);
      return int'(clamp(acc >>> 23, -128, 127));
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Drives one sample; reports the done cycle (edges after the accepting
   // edge, -1 if none), number of done pulses in the window and the output.
   task automatic run_sample(input int x, input int e, input bit ad,
                             output int dcyc, output int npulse, output int sout);
      dcyc   = -1;
      npulse = 0;
      sout   = 0;
      @(posedge clk); #1;
      bus.ready_in        = 1'b1;
      bus.x_sample_in     = 16'(x);
      bus.error_sample_in = 16'(e);
      bus.adapt_en_in     = ad;
      @(posedge clk); #1;
      bus.ready_in = 1'b0;
      for (int n = 1; n <= LAT + 3; n++) begin
         @(posedge clk); #1;
         if (bus.done_out) begin
            npulse++;
            if (dcyc < 0) begin
               dcyc = n;
               sout = bus.speaker_output_out;
            end
         end
      end
   endtask

   task automatic test_reset();
      int got;
      rst_n = 1'b0;
      bus.ready_in = 1'b0; bus.adapt_en_in = 1'b0;
      bus.x_sample_in = '0; bus.error_sample_in = '0;
      repeat (3) @(posedge clk);
      #1;
      got = bus.speaker_output_out;
      total++; if (got !== 0) begin bad++; $display("FAIL reset_speaker got=%0d want=0", got); end
      total++; if (bus.done_out !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done_out); end
      total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_out); end
      total++; if (bus.overrun_out !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun_out); end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_frozen();
      int dcyc, np, sout, exp;
      exp = model_step(16384, 1000, 1'b0);
      run_sample(16384, 1000, 1'b0, dcyc, np, sout);
      total++; if (dcyc !== LAT) begin bad++; $display("FAIL frozen_latency got=%0d want=%0d", dcyc, LAT); end
      total++; if (np !== 1) begin bad++; $display("FAIL frozen_pulses got=%0d want=1", np); end
      total++; if (sout !== exp) begin bad++; $display("FAIL frozen_out got=%0d want=%0d", sout, exp); end
      total++; if (bus.overrun_out !== 1'b0) begin bad++; $display("FAIL frozen_overrun got=%b want=0", bus.overrun_out); end
   endtask

   task automatic test_single_adapt();
      int dcyc, np, sout, exp;
      do_reset();
      exp = model_step(16384, 0, 1'b1);
      run_sample(16384, 0, 1'b1, dcyc, np, sout);
      total++; if (sout !== exp) begin bad++; $display("FAIL adapt1_out got=%0d want=%0d", sout, exp); end
      exp = model_step(16384, 8192, 1'b1);
      run_sample(16384, 8192, 1'b1, dcyc, np, sout);
      total++; if (sout !== exp) begin bad++; $display("FAIL adapt2_out got=%0d want=%0d", sout, exp); end
      total++; if (sout !== -64) begin bad++; $display("FAIL adapt2_const got=%0d want=-64", sout); end
      total++; if (dcyc !== LAT) begin bad++; $display("FAIL adapt2_latency got=%0d want=%0d", dcyc, LAT); end
   endtask

   task automatic test_saturation();
      int dcyc, np, sout, exp;
      exp = model_step(-32768, 0, 1'b0);
      run_sample(-32768, 0, 1'b0, dcyc, np, sout);
      total++; if (sout !== 127) begin bad++; $display("FAIL sat8_clamp got=%0d want=127", sout); end
      total++; if (sout !== exp) begin bad++; $display("FAIL sat8_model got=%0d want=%0d", sout, exp); end
      exp = model_step(16384, 0, 1'b0);
      run_sample(16384, 0, 1'b0, dcyc, np, sout);
      total++; if (sout !== exp) begin bad++; $display("FAIL sat_s2 got=%0d want=%0d", sout, exp); end
      exp = model_step(0, 32767, 1'b1);
      run_sample(0, 32767, 1'b1, dcyc, np, sout);
      total++; if (sout !== exp) begin bad++; $display("FAIL sat_coef_s3 got=%0d want=%0d", sout, exp); end
      exp = model_step(0, 0, 1'b0);
      run_sample(0, 0, 1'b0, dcyc, np, sout);
      total++; if (sout !== exp) begin bad++; $display("FAIL sat_coef_s4 got=%0d want=%0d", sout, exp); end
   endtask

   task automatic test_overrun();
      int dcyc, np, sout, exp, got;
      logic ov_before, ov_after, busy_mid;
      do_reset();
      ov_before = 1'bx; ov_after = 1'bx; busy_mid = 1'bx;
      exp = model_step(30000, 0, 1'b1);
      @(posedge clk); #1;
      bus.ready_in = 1'b1; bus.x_sample_in = 16'(30000);
      bus.error_sample_in = '0; bus.adapt_en_in = 1'b1;
      @(posedge clk); #1;
      bus.ready_in = 1'b0;
      dcyc = -1; np = 0; sout = 0;
      for (int n = 1; n <= LAT + 3; n++) begin
         if (n == 10) begin
            bus.ready_in = 1'b1; bus.x_sample_in = 16'(-20000);
            bus.error_sample_in = 16'(12345);
         end
         if (n == 11) bus.ready_in = 1'b0;
         @(posedge clk); #1;
         if (n == 5)  busy_mid  = bus.busy_out;
         if (n == 9)  ov_before = bus.overrun_out;
         if (n == 11) ov_after  = bus.overrun_out;
         if (bus.done_out) begin
            np++;
            if (dcyc < 0) begin dcyc = n; sout = bus.speaker_output_out; end
         end
      end
      total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL ovr_busy got=%b want=1", busy_mid); end
      total++; if (ov_before !== 1'b0) begin bad++; $display("FAIL ovr_before got=%b want=0", ov_before); end
      total++; if (ov_after !== 1'b1) begin bad++; $display("FAIL ovr_after got=%b want=1", ov_after); end
      total++; if (np !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", np); end
      total++; if (dcyc !== LAT) begin bad++; $display("FAIL ovr_latency got=%0d want=%0d", dcyc, LAT); end
      total++; if (sout !== exp) begin bad++; $display("FAIL ovr_out1 got=%0d want=%0d", sout, exp); end
      exp = model_step(30000, 30000, 1'b1);
      run_sample(30000, 30000, 1'b1, dcyc, np, sout);
      total++; if (sout !== exp) begin bad++; $display("FAIL ovr_out3 got=%0d want=%0d", sout, exp); end
      total++; if (dcyc !== LAT) begin bad++; $display("FAIL ovr_latency3 got=%0d want=%0d", dcyc, LAT); end
      got = bus.overrun_out;
      total++; if (got !== 1) begin bad++; $display("FAIL ovr_sticky got=%0d want=1", got); end
   endtask

   task automatic test_pointer_wrap();
      int dcyc, np, sout, exp;
      do_reset();
      // Push an impulse to the oldest tap, then adapt so only w[NUM_TAPS-1] is set.
      for (int i = 0; i < NUM_TAPS; i++) begin
         exp = model_step((i == 0) ? 16384 : 0, 0, 1'b0);
         run_sample((i == 0) ? 16384 : 0, 0, 1'b0, dcyc, np, sout);
      end
      exp = model_step(0, 8192, 1'b1);
      run_sample(0, 8192, 1'b1, dcyc, np, sout);
      total++; if (sout !== exp) begin bad++; $display("FAIL wrap_preload got=%0d want=%0d", sout, exp); end
      for (int n = 1; n <= 40; n++) begin
         exp = model_step((n == 1) ? 16384 : 0, 0, 1'b0);
         run_sample((n == 1) ? 16384 : 0, 0, 1'b0, dcyc, np, sout);
         total++;
         if (sout !== exp) begin bad++; $display("FAIL wrap_s%0d got=%0d want=%0d", n, sout, exp); end
         if (n == NUM_TAPS) begin
            total++; if (sout !== -64) begin bad++; $display("FAIL wrap_last got=%0d want=-64", sout); end
         end
         if (n == NUM_TAPS + 1) begin
            total++; if (sout !== 0) begin bad++; $display("FAIL wrap_gone got=%0d want=0", sout); end
         end
      end
   endtask

   task automatic test_random();
      int dcyc, np, sout, exp, xr, er, gap;
      bit ad;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         xr  = int'($urandom_range(65535)) - 32768;
         er  = int'($urandom_range(8191)) - 4096;
         if (i % 3 == 0) xr = xr >>> 3;
         ad  = 1'($urandom_range(1));
         gap = int'($urandom_range(3));
         repeat (gap) @(posedge clk);
         exp = model_step(xr, er, ad);
         run_sample(xr, er, ad, dcyc, np, sout);
         total++; if (sout !== exp) begin bad++; $display("FAIL rand_out_%0d got=%0d want=%0d", i, sout, exp); end
         total++; if (dcyc !== LAT) begin bad++; $display("FAIL rand_lat_%0d got=%0d want=%0d", i, dcyc, LAT); end
      end
   endtask

   task automatic test_async_reset();
      int dcyc, np, sout, exp, got, pulses;
      do_reset();
      exp = model_step(16384, 0, 1'b0);
      run_sample(16384, 0, 1'b0, dcyc, np, sout);
      exp = model_step(16384, 8192, 1'b1);
      run_sample(16384, 8192, 1'b1, dcyc, np, sout);
      total++; if (sout !== exp) begin bad++; $display("FAIL arst_pre_out got=%0d want=%0d", sout, exp); end
      @(posedge clk); #1;
      bus.ready_in = 1'b1; bus.x_sample_in = 16'(16384);
      bus.error_sample_in = '0; bus.adapt_en_in = 1'b0;
      @(posedge clk); #1;
      bus.ready_in = 1'b0;
      repeat (40) @(posedge clk);
      #2;
      total++; if (bus.busy_out !== 1'b1) begin bad++; $display("FAIL arst_busy_mid got=%b want=1", bus.busy_out); end
      rst_n = 1'b0;
      #1;
      model_reset();
      got = bus.speaker_output_out;
      total++; if (got !== 0) begin bad++; $display("FAIL arst_speaker got=%0d want=0", got); end
      total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", bus.busy_out); end
      total++; if (bus.done_out !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", bus.done_out); end
      pulses = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.done_out) pulses++;
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done_out) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL arst_no_done got=%0d want=0", pulses); end
      exp = model_step(16384, 0, 1'b0);
      run_sample(16384, 0, 1'b0, dcyc, np, sout);
      total++; if (sout !== exp) begin bad++; $display("FAIL arst_after got=%0d want=%0d", sout, exp); end
      total++; if (dcyc !== LAT) begin bad++; $display("FAIL arst_latency got=%0d want=%0d", dcyc, LAT); end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ready_in = 1'b0;
      bus.adapt_en_in = 1'b0;
      bus.x_sample_in = '0;
      bus.error_sample_in = '0;
      test_reset();
      test_frozen();
      test_single_adapt();
      test_saturation();
      test_overrun();
      test_pointer_wrap();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/anc_lms_filter.md
Name: anc_lms_filter

Overview:
- Adaptive LMS FIR filter that generates the anti-noise speaker drive for the ANC loop.
- Consumes the ambient reference sample and the feedback (error) sample, which the cup simulator produces on the bench and the in-ear mic produces on hardware.
- Produces the signed 8-bit speaker sample that feeds the cup/speaker stage directly downstream.
- Time-multiplexed: one MAC per cycle, serial over taps, driven by a ready/done sample handshake.

Parameters:
- NUM_TAPS, 32, number of FIR taps; power of two, 4..64.
- MU_SHIFT, 12, step size as arithmetic right shift of the e*x product.
- COEF_W, 16, coefficient width, signed Q1.15.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- ready_in  input  1  one-cycle pulse: new sample pair valid
- adapt_en_in  input  1  1 = update coefficients; 0 = coefficients frozen
- x_sample_in  input  16  signed ambient reference sample, Q1.15
- error_sample_in  input  16  signed feedback/error sample for the previous output, Q1.15
- speaker_output_out  output  8  signed anti-noise sample
- done_out  output  1  one-cycle pulse: speaker_output_out updated
- busy_out  output  1  high while not IDLE
- overrun_out  output  1  sticky: ready_in arrived while busy

Behaviour:
- Reset: rst_n_in low, asynchronous.
  - Outputs: speaker_output_out=0, done_out=0, busy_out=0, overrun_out=0.
  - Internal: all coefficients w[k]=0, history x[k]=0, state=IDLE.
  - Reset mid-operation aborts; no done_out pulse follows.
- Storage: history is a circular buffer of NUM_TAPS entries. x[0] is the newest sample and x[NUM_TAPS-1] the oldest.
- FSM: IDLE -> UPDATE -> INSERT -> FILTER -> OUTPUT -> IDLE.
  - IDLE: on ready_in, latch x_sample_in and error_sample_in into registers, then go to UPDATE.
  - UPDATE: NUM_TAPS cycles, one tap k per cycle, using history before insertion.
    - If adapt_en_in=1 (sampled at latch time): w[k] <= sat_COEF_W( w[k] - ((e*x[k]) >>> MU_SHIFT) ).
    - If adapt_en_in=0: coefficients unchanged; the state still takes NUM_TAPS cycles.
  - INSERT: 1 cycle. The latched x becomes x[0] and the oldest entry is discarded via pointer wrap.
  - FILTER: NUM_TAPS cycles. acc = sum over k of w[k]*x[k], with the accumulator cleared on entry.
  - OUTPUT: 1 cycle. speaker_output_out <= sat8(acc >>> 23) and done_out=1 for exactly this cycle.
- Latency: ready_in sampled at edge 0 gives done_out high in cycle 2*NUM_TAPS+2 (66 at default). speaker_output_out holds its value until the next OUTPUT.
- Arithmetic:
  - e*x and w*x are 32-bit signed products.
  - Shifts are arithmetic, truncating toward -inf.
  - Coefficient saturation range is [-32768, 32767].
  - Accumulator is 32+log2(NUM_TAPS) bits, so it never wraps.
  - sat8 clamps to [-128, 127].
- Sign convention: the downstream stage adds the speaker output to ambient, hence the minus sign in the update.
- Handshake: ready_in while busy_out=1 is dropped and sets overrun_out, which clears only on reset. ready_in in the same cycle as the OUTPUT state is also dropped; it is accepted only in IDLE.
- Pointer wrap: the history write pointer wraps modulo NUM_TAPS. Tap index k maps to address (wr_ptr - 1 - k) mod NUM_TAPS.

Test Plan:
- Reset/frozen: reset, adapt_en_in=0, ready_in with x=16384, e=1000 -> done_out pulses once in cycle 66; speaker_output_out=0; overrun_out=0.
- Single adaptation: adapt_en_in=1, MU_SHIFT=12.
  - Sample 1: x=16384, e=0 -> output 0.
  - Sample 2: x=16384, e=8192 -> w[0]=-32768; output = sat8((-32768*16384)>>>23) = -64, done in cycle 66.
- Saturation: continue from w[0]=-32768 with adapt_en_in=0, x=-32768 -> product 2^30 >>>23 = 128, output clamps to 127. Further adaptation with e=32767 keeps w[0] at -32768 with no wrap.
- Overrun: ready_in at cycle 0 and cycle 10 -> one done_out only (cycle 66); overrun_out=1 from cycle 11 until reset; a third ready_in at cycle 70 is processed normally.
- Pointer wrap: feed 40 samples with an impulse x=16384 at sample 1, w[NUM_TAPS-1] preloaded via adaptation -> the impulse contributes only while within the last 32 samples; its contribution is zero from sample 33 onward.
- Async reset mid-FILTER: drop rst_n_in at cycle 40 -> outputs 0 immediately, with no clock edge required; no done_out pulse; the next sample after release yields output 0, confirming coefficients were cleared.
